// File: rtl/multi_link_data_mux_if.sv
// Bundle for multi_link_data_mux: raw receive channels in, aligned word stream
// and status out.
//   slave  modport : the multiplexer side (channels/config in, word/status out)
//   master modport : the feeding/consuming side (mirror of slave)
// Signals:
//   ch_data      NUM_CH*WORD_W  channel k at [k*WORD_W +: WORD_W]
//   ch_valid     NUM_CH         per-channel word/byte strobe
//   ch_link_ok   NUM_CH         per-channel alignment-good flag
//   ch_byte_mode NUM_CH         1 = channel carries bytes in ch_data[7:0]
//   sel_cfg      SEL_W          requested channel (manual mode)
//   auto_mode    1              1 = automatic failover
//   dout/dout_valid             packed word and its one-cycle strobe
//   active_sel/mux_state        routed channel, 00 IDLE 01 SETTLE 10 RUN 11 NOLINK
//   cfg_err/link_err_cnt/switch_cnt  status
//   dout_parity  1              even parity of dout, only with MUX_PARITY_EN
interface multi_link_data_mux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WORD_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_link_ok;
  logic [NUM_CH-1:0]        ch_byte_mode;
  logic [SEL_W-1:0]         sel_cfg;
  logic                     auto_mode;
  logic [WORD_W-1:0]        dout;
  logic                     dout_valid;
  logic [SEL_W-1:0]         active_sel;
  logic [1:0]               mux_state;
  logic                     cfg_err;
  logic [CNT_W-1:0]         link_err_cnt;
  logic [CNT_W-1:0]         switch_cnt;
`ifdef MUX_PARITY_EN
  logic                     dout_parity;
`endif

  modport slave (
    input  ch_data, ch_valid, ch_link_ok, ch_byte_mode, sel_cfg, auto_mode,
    output dout, dout_valid, active_sel, mux_state, cfg_err, link_err_cnt,
           switch_cnt
`ifdef MUX_PARITY_EN
    , output dout_parity
`endif
  );

  modport master (
    output ch_data, ch_valid, ch_link_ok, ch_byte_mode, sel_cfg, auto_mode,
    input  dout, dout_valid, active_sel, mux_state, cfg_err, link_err_cnt,
           switch_cnt
`ifdef MUX_PARITY_EN
    , input dout_parity
`endif
  );
endinterface

// File: rtl/multi_link_data_mux.sv
// multi_link_data_mux: selects one of NUM_CH receive channels (32-bit words or
// 8-bit bytes) and delivers an aligned WORD_W-bit word stream, with manual or
// automatic failover, a SETTLE_CYC blanking window after reset/switch, a
// byte-to-word packer (first byte lands in the MSB) and saturating counters.
// Ports:
//   clk40  system clock, rising edge
//   rstn   synchronous reset, active low
//   bus    multi_link_data_mux_if.slave (channels/config in, word/status out)
// Optional: MUX_PARITY_EN adds bus.dout_parity = ^dout, registered with dout.
module multi_link_data_mux #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk40,
  input  logic                   rstn,
  multi_link_data_mux_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);
  localparam int unsigned BPW   = WORD_W / 8;
  localparam int unsigned BC_W  = $clog2(BPW) + 1;
  localparam int unsigned ST_W  = $clog2(SETTLE_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RUN    = 2'b10,
    S_NOLINK = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              bmode_q, bmode_d;
  logic              cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]  lerr_q, lerr_d;
  logic [CNT_W-1:0]  swc_q, swc_d;

  logic [WORD_W-1:0] cur_data, packed_w;
  logic              cur_valid, cur_ok, cur_bmode;
  logic              any_ok, nxt_found, sel_cfg_bad;
  logic [SEL_W-1:0]  lowest_ok, nxt_ok;

  always_comb begin : ch_view
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_ok    = 1'b0;
    cur_bmode = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) begin
        cur_data  = bus.ch_data[k*WORD_W +: WORD_W];
        cur_valid = bus.ch_valid[k];
        cur_ok    = bus.ch_link_ok[k];
        cur_bmode = bus.ch_byte_mode[k];
      end
    end
  end

  // Lowest healthy channel (initial/NOLINK pick) and nearest healthy channel
  // above the active one with wrap (failover pick, by rotational distance).
  always_comb begin : ch_search
    int unsigned d;
    int unsigned best_d;
    d         = 0;
    best_d    = NUM_CH;
    any_ok    = 1'b0;
    lowest_ok = '0;
    nxt_ok    = '0;
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      if (bus.ch_link_ok[k-1]) begin
        any_ok    = 1'b1;
        lowest_ok = SEL_W'(k-1);
      end
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      d = k + NUM_CH - 32'(sel_q);
      if (d >= NUM_CH) d = d - NUM_CH;
      if (bus.ch_link_ok[k] && d != 0 && d < best_d) begin
        best_d = d;
        nxt_ok = SEL_W'(k);
      end
    end
    nxt_found = (best_d != NUM_CH);
  end

  assign sel_cfg_bad = (32'(bus.sel_cfg) >= NUM_CH);
  assign packed_w    = (pack_q << 8) | WORD_W'(cur_data[7:0]);

  always_comb begin : fsm_next
    state_d   = state_q;
    settle_d  = settle_q;
    sel_d     = sel_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    pack_d    = pack_q;
    bcnt_d    = bcnt_q;
    bmode_d   = bmode_q;
    cfg_err_d = cfg_err_q | sel_cfg_bad;
    lerr_d    = lerr_q;
    swc_d     = swc_q;
    case (state_q)
      S_IDLE: begin
        pack_d   = '0;
        bcnt_d   = '0;
        settle_d = '0;
        if (bus.auto_mode) begin
          if (any_ok) begin
            sel_d   = lowest_ok;
            state_d = S_SETTLE;
          end else begin
            state_d = S_NOLINK;
          end
        end else begin
          if (!sel_cfg_bad) sel_d = bus.sel_cfg;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        pack_d   = '0;
        bcnt_d   = '0;
        bmode_d  = cur_bmode;
        settle_d = settle_q + ST_W'(1);
        if (settle_q == ST_W'(SETTLE_CYC - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!cur_ok && lerr_q != '1) lerr_d = lerr_q + CNT_W'(1);
        if (bus.auto_mode && !cur_ok) begin
          pack_d   = '0;
          bcnt_d   = '0;
          settle_d = '0;
          if (nxt_found) begin
            sel_d   = nxt_ok;
            state_d = S_SETTLE;
            if (swc_q != '1) swc_d = swc_q + CNT_W'(1);
          end else begin
            state_d = S_NOLINK;
          end
        end else if (!bus.auto_mode && !sel_cfg_bad && bus.sel_cfg != sel_q) begin
          pack_d   = '0;
          bcnt_d   = '0;
          settle_d = '0;
          sel_d    = bus.sel_cfg;
          state_d  = S_SETTLE;
          if (swc_q != '1) swc_d = swc_q + CNT_W'(1);
        end else if (cur_bmode != bmode_q) begin
          // mode flip mid-word: drop the partial word and this cycle's data
          bmode_d = cur_bmode;
          pack_d  = '0;
          bcnt_d  = '0;
        end else if (cur_valid) begin
          if (!cur_bmode) begin
            dout_d   = cur_data;
            dvalid_d = 1'b1;
          end else if (bcnt_q == BC_W'(BPW - 1)) begin
            dout_d   = packed_w;
            dvalid_d = 1'b1;
            pack_d   = '0;
            bcnt_d   = '0;
          end else begin
            pack_d = packed_w;
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        pack_d   = '0;
        bcnt_d   = '0;
        settle_d = '0;
        if (any_ok) begin
          sel_d   = lowest_ok;
          state_d = S_SETTLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk40) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      sel_q     <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      pack_q    <= '0;
      bcnt_q    <= '0;
      bmode_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      lerr_q    <= '0;
      swc_q     <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      pack_q    <= pack_d;
      bcnt_q    <= bcnt_d;
      bmode_q   <= bmode_d;
      cfg_err_q <= cfg_err_d;
      lerr_q    <= lerr_d;
      swc_q     <= swc_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk40) begin
    if (!rstn) par_q <= 1'b0;
    else       par_q <= ^dout_d;
  end
  assign bus.dout_parity = par_q;
`endif

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dvalid_q;
  assign bus.active_sel   = sel_q;
  assign bus.mux_state    = state_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.link_err_cnt = lerr_q;
  assign bus.switch_cnt   = swc_q;
endmodule

// File: tb/tb_multi_link_data_mux.sv
// Bench for multi_link_data_mux: a behavioural reference model predicts routed
// words (pushed into a queue) and status per cycle; a separate monitor pops a
// word whenever dout_valid is seen.
module tb_multi_link_data_mux;
  localparam int unsigned NCH  = 5;
  localparam int unsigned WW   = 32;
  localparam int unsigned SC   = 8;
  localparam int unsigned CW   = 5;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk40 = 1'b0;
  logic rstn  = 1'b0;

  multi_link_data_mux_if #(.NUM_CH(NCH), .WORD_W(WW), .CNT_W(CW)) bus ();

  multi_link_data_mux #(
    .NUM_CH(NCH), .WORD_W(WW), .SETTLE_CYC(SC), .CNT_W(CW)
  ) dut (
    .clk40(clk40),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk40 = ~clk40;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase 0 idle, 1 settle, 2 run, 3 nolink
  int               m_phase = 0, m_left = 0, m_sel = 0, m_lec = 0, m_swc = 0;
  bit               m_cfg = 1'b0, m_lastmode = 1'b0;
  logic [WW-1:0]    m_dout = '0;
  byte unsigned     m_bytes[$];
  logic [WW-1:0]    exp_q[$];
  logic [WW-1:0]    mon_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_ok();
    for (int k = 0; k < NCH; k++) if (bus.ch_link_ok[k]) return k;
    return -1;
  endfunction

  task automatic enter_settle();
    m_phase = 1;
    m_left  = SC;
    m_bytes.delete();
  endtask

  task automatic bump_swc();
    if (m_swc < CMAX) m_swc++;
  endtask

  task automatic emit(input logic [WW-1:0] w);
    exp_q.push_back(w);
    m_dout = w;
  endtask

  task automatic run_step();
    bit            ok, mode;
    int            nxt;
    logic [WW-1:0] w;
    ok  = bus.ch_link_ok[m_sel];
    nxt = -1;
    if (!ok && m_lec < CMAX) m_lec++;
    if (bus.auto_mode && !ok) begin
      for (int d = 1; d < NCH; d++)
        if (nxt < 0 && bus.ch_link_ok[(m_sel + d) % NCH]) nxt = (m_sel + d) % NCH;
      if (nxt >= 0) begin
        m_sel = nxt;
        bump_swc();
        enter_settle();
      end else begin
        m_phase = 3;
        m_bytes.delete();
      end
    end else if (!bus.auto_mode && int'(bus.sel_cfg) < NCH && int'(bus.sel_cfg) != m_sel) begin
      m_sel = int'(bus.sel_cfg);
      bump_swc();
      enter_settle();
    end else begin
      mode = bus.ch_byte_mode[m_sel];
      if (mode != m_lastmode) begin
        m_lastmode = mode;
        m_bytes.delete();
      end else if (bus.ch_valid[m_sel]) begin
        w = bus.ch_data[m_sel*WW +: WW];
        if (!mode) emit(w);
        else begin
          m_bytes.push_back(w[7:0]);
          if (m_bytes.size() == WW / 8) begin
            w = '0;
            foreach (m_bytes[i]) w = (w << 8) | WW'(m_bytes[i]);
            m_bytes.delete();
            emit(w);
          end
        end
      end
    end
  endtask

  // Effect of the coming clock edge given the inputs currently driven.
  task automatic model_step();
    int lo;
    if (!rstn) begin
      m_phase = 0; m_sel = 0; m_dout = '0; m_cfg = 1'b0;
      m_lec = 0; m_swc = 0; m_bytes.delete();
      return;
    end
    if (int'(bus.sel_cfg) >= NCH) m_cfg = 1'b1;
    lo = lowest_ok();
    case (m_phase)
      0: begin
        m_bytes.delete();
        if (bus.auto_mode) begin
          if (lo < 0) m_phase = 3;
          else begin m_sel = lo; enter_settle(); end
        end else begin
          if (int'(bus.sel_cfg) < NCH) m_sel = int'(bus.sel_cfg);
          enter_settle();
        end
      end
      1: begin
        m_bytes.delete();
        m_lastmode = bus.ch_byte_mode[m_sel];
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: run_step();
      default: begin
        m_bytes.delete();
        if (lo >= 0) begin m_sel = lo; enter_settle(); end
      end
    endcase
  endtask

  task automatic check_state();
    check("mux_state",    64'(bus.mux_state),    64'(m_phase));
    check("active_sel",   64'(bus.active_sel),   64'(m_sel));
    check("dout_hold",    64'(bus.dout),         64'(m_dout));
    check("cfg_err",      64'(bus.cfg_err),      64'(m_cfg));
    check("link_err_cnt", 64'(bus.link_err_cnt), 64'(m_lec));
    check("switch_cnt",   64'(bus.switch_cnt),   64'(m_swc));
    check("pending_words", 64'(exp_q.size()), 64'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk40);
    @(negedge clk40);
    check_state();
  endtask

  task automatic rand_data(input int vperc);
    for (int k = 0; k < NCH; k++) begin
      bus.ch_data[k*WW +: WW] = $urandom;
      bus.ch_valid[k]         = ($urandom % 100) < vperc;
    end
  endtask

  task automatic send_byte(input int ch, input logic [7:0] b);
    rand_data(0);
    bus.ch_data[ch*WW +: 8] = b;
    bus.ch_valid[ch]        = 1'b1;
    tick();
  endtask

  task automatic wait_run(input int vperc);
    int n;
    n = 0;
    while (m_phase != 2 && n < 60) begin
      rand_data(vperc);
      tick();
      n++;
    end
    check("reach_run", 64'(bus.mux_state), 64'd2);
  endtask

  // monitor: consumes one predicted word per observed dout_valid strobe
  always @(posedge clk40) begin
    #1;
    if (bus.dout_valid !== 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_valid", 64'(bus.dout_valid), 64'd0);
      else begin
        mon_w = exp_q.pop_front();
        check("dout_word", 64'(bus.dout), 64'(mon_w));
`ifdef MUX_PARITY_EN
        check("dout_parity", 64'(bus.dout_parity), 64'(^mon_w));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_data      = '0;
    bus.ch_valid     = '0;
    bus.ch_link_ok   = '1;
    bus.ch_byte_mode = '0;
    bus.sel_cfg      = 3'd2;
    bus.auto_mode    = 1'b0;
    rstn             = 1'b0;
    repeat (3) tick();
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_state", 64'(bus.mux_state), 64'd0);
    rstn = 1'b1;

    // manual ch2, word mode
    for (int i = 0; i < 30; i++) begin
      rand_data(50);
      if (i == 9)  begin bus.ch_data[2*WW +: WW] = 32'hDEADBEEF; bus.ch_valid[2] = 1'b1; end
      if (i == 10) begin bus.ch_data[2*WW +: WW] = 32'h00000007; bus.ch_valid[2] = 1'b1; end
      tick();
      if (i == 9) check("t1_dout", 64'(bus.dout), 64'hDEADBEEF);
`ifdef MUX_PARITY_EN
      if (i == 10) check("t6_parity", 64'(bus.dout_parity), 64'd1);
`endif
    end
    check("t1_switch_cnt", 64'(bus.switch_cnt), 64'd0);

    // manual switch to ch1 in byte mode
    bus.ch_byte_mode[1] = 1'b1;
    bus.sel_cfg = 3'd1;
    rand_data(50);
    tick();
    wait_run(50);
    check("t2_sel", 64'(bus.active_sel), 64'd1);
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    send_byte(1, 8'h33);
    send_byte(1, 8'h44);
    check("t2_dout", 64'(bus.dout), 64'h11223344);
    for (int i = 0; i < 40; i++) begin rand_data(60); tick(); end

    // auto failover
    bus.ch_byte_mode = '0;
    bus.sel_cfg = 3'd0;
    rand_data(50);
    tick();
    wait_run(50);
    check("t3_switch_pre", 64'(bus.switch_cnt), 64'd2);
    bus.auto_mode  = 1'b1;
    bus.ch_link_ok = 5'b01010;
    rand_data(50);
    tick();
    check("t3_sel", 64'(bus.active_sel), 64'd1);
    check("t3_settle", 64'(bus.mux_state), 64'd1);
    check("t3_switch", 64'(bus.switch_cnt), 64'd3);
    for (int j = 0; j < 8; j++) begin
      rand_data(50);
      tick();
      check("t3_settle_len", 64'(bus.mux_state), (j < 7) ? 64'd1 : 64'd2);
    end
    bus.ch_link_ok = '0;
    rand_data(50);
    tick();
    check("t3_nolink", 64'(bus.mux_state), 64'd3);
    for (int j = 0; j < 5; j++) begin
      rand_data(100);
      tick();
      check("t3_nolink_valid", 64'(bus.dout_valid), 64'd0);
    end
    bus.ch_link_ok = 5'b10100;
    rand_data(50);
    tick();
    check("t3_relink_sel", 64'(bus.active_sel), 64'd2);
    for (int i = 0; i < 300; i++) begin
      rand_data(50);
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 99) < 4) bus.ch_link_ok[k] = ~bus.ch_link_ok[k];
      tick();
    end

    // invalid manual selection and link-error counting
    bus.auto_mode  = 1'b0;
    bus.ch_link_ok = '1;
    bus.sel_cfg    = 3'd5;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wait_run(50);
    check("t4_cfg_err", 64'(bus.cfg_err), 64'd1);
    check("t4_sel", 64'(bus.active_sel), 64'd0);
    bus.ch_link_ok[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_data(50); tick(); end
    check("t4_lec", 64'(bus.link_err_cnt), 64'd10);
    for (int i = 0; i < 30; i++) begin rand_data(50); tick(); end
    check("t4_lec_sat", 64'(bus.link_err_cnt), 64'(CMAX));

    // reset in the middle of a byte-mode word
    bus.ch_link_ok = '1;
    bus.sel_cfg    = 3'd0;
    bus.ch_byte_mode[0] = 1'b1;
    rand_data(0);
    tick();
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    rstn = 1'b0;
    rand_data(100);
    tick();
    check("t5_dout", 64'(bus.dout), 64'd0);
    check("t5_state", 64'(bus.mux_state), 64'd0);
    check("t5_switch", 64'(bus.switch_cnt), 64'd0);
    rstn = 1'b1;
    wait_run(0);
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    send_byte(0, 8'h03);
    send_byte(0, 8'h04);
    check("t5_dout_restart", 64'(bus.dout), 64'h01020304);

    // mixed random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_data(60);
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 99) < 3) bus.ch_link_ok[k]   = ~bus.ch_link_ok[k];
        if ($urandom_range(0, 99) < 1) bus.ch_byte_mode[k] = ~bus.ch_byte_mode[k];
      end
      if ($urandom_range(0, 99) < 3) bus.sel_cfg = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 1) bus.auto_mode = ~bus.auto_mode;
      rstn = ($urandom_range(0, 399) != 0);
      tick();
    end

    rstn = 1'b1;
    rand_data(0);
    tick();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
